vic_reg_bus_initiator: RTL and testbench

//  CPU-side bus initiator for the VIC-II register interface: the master end of ce/rw/adl/dbl.

---
 rtl/vic_reg_bus_initiator.sv | 206 ++++++++++++++++++++
 tb/tb_vic_reg_bus_initiator.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vic_reg_bus_initiator.sv
// CPU-side bus initiator for the VIC-II register interface.
// Turns one command from a valid/ready port into exactly one phi-high bus cycle
// (ce/rw/address/data) and returns the result on a valid/ready response port.
//
// Ports:
//   clk_dot4x, rst_n          dot clock, async active-low reset
//   clk_phi, aec              phi from the vicii; CPU bus ownership for this phi-high phase
//   cmd_valid/ready/write/addr/wdata   command port
//   rsp_valid/ready/rdata/err          response port (rdata 0 for writes, all-ones on abort)
//   ce, rw, ad_o, ad_oe, db_o, db_oe   registered bus drive toward the vicii
//   db_i                      data bus sampled for reads
module vic_reg_bus_initiator #(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SETUP_TICKS = 2,
  parameter int unsigned SAMPLE_TICK = 12,
  parameter int unsigned TIMEOUT_PHI = 16
) (
  input  logic              clk_dot4x,
  input  logic              rst_n,
  input  logic              clk_phi,
  input  logic              aec,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              ce,
  output logic              rw,
  output logic [ADDR_W-1:0] ad_o,
  output logic              ad_oe,
  output logic [DATA_W-1:0] db_o,
  output logic              db_oe,
  input  logic [DATA_W-1:0] db_i
);

  localparam int unsigned TickW = $clog2(SAMPLE_TICK + 2);
  localparam int unsigned ToW   = $clog2(TIMEOUT_PHI + 1);

  typedef enum logic [2:0] {StIdle, StWaitRise, StSetup, StAccess, StResp} state_e;

  state_e              state_q, state_d;
  logic                phi_q;
  logic [TickW-1:0]    tick_q, tick_d, tick_inc;
  logic [ToW-1:0]      to_q, to_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                ce_q, ce_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   ad_q, ad_d;
  logic                ad_oe_q, ad_oe_d;
  logic [DATA_W-1:0]   db_q, db_d;
  logic                db_oe_q, db_oe_d;

  logic rise, fall;

  // clk_phi is derived from clk_dot4x, so a single delay stage is enough for edge detection
  assign rise = clk_phi & ~phi_q;
  assign fall = ~clk_phi & phi_q;

  // Saturating tick increment
  assign tick_inc = (tick_q == '1) ? tick_q : tick_q + TickW'(1);

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    to_d      = to_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    ce_d      = ce_q;
    rw_d      = rw_q;
    ad_d      = ad_q;
    ad_oe_d   = ad_oe_q;
    db_d      = db_q;
    db_oe_d   = db_oe_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready_q) begin
          wr_d    = cmd_write;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          to_d    = '0;
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = StWaitRise;
        end
      end
      StWaitRise: begin
        // Ownership is decided only at the rise; an accept mid-phase waits for the next rise
        if (rise) begin
          if (aec) begin
            tick_d  = '0;
            state_d = StSetup;
          end else if (to_q >= ToW'(TIMEOUT_PHI - 1)) begin
            err_d   = 1'b1;
            rdata_d = '1;
            state_d = StResp;
          end else begin
            to_d = to_q + ToW'(1);
          end
        end
      end
      StSetup: begin
        tick_d = tick_inc;
        if (tick_q == TickW'(SETUP_TICKS - 1)) begin
          ce_d    = 1'b0;
          rw_d    = ~wr_q;
          ad_d    = addr_q;
          ad_oe_d = 1'b1;
          db_d    = wr_q ? wdata_q : '0;
          db_oe_d = wr_q;
          state_d = StAccess;
        end
      end
      StAccess: begin
        tick_d = tick_inc;
        if (!wr_q && tick_q == TickW'(SAMPLE_TICK)) begin
          rdata_d = db_i;
        end
        // Bus released on the same edge that registers the fall; aec is ignored here
        if (fall) begin
          ce_d    = 1'b1;
          rw_d    = 1'b1;
          ad_oe_d = 1'b0;
          db_oe_d = 1'b0;
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    cmd_ready_d = (state_d == StIdle);
    rsp_valid_d = (state_d == StResp);
  end

  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      phi_q       <= 1'b0;
      tick_q      <= '0;
      to_q        <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      ce_q        <= 1'b1;
      rw_q        <= 1'b1;
      ad_q        <= '0;
      ad_oe_q     <= 1'b0;
      db_q        <= '0;
      db_oe_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      phi_q       <= clk_phi;
      tick_q      <= tick_d;
      to_q        <= to_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      ce_q        <= ce_d;
      rw_q        <= rw_d;
      ad_q        <= ad_d;
      ad_oe_q     <= ad_oe_d;
      db_q        <= db_d;
      db_oe_q     <= db_oe_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign ce        = ce_q;
  assign rw        = rw_q;
  assign ad_o      = ad_q;
  assign ad_oe     = ad_oe_q;
  assign db_o      = db_q;
  assign db_oe     = db_oe_q;

endmodule

// File: tb/tb_vic_reg_bus_initiator.sv
module tb_vic_reg_bus_initiator;

  localparam int PHI_HALF    = 16;  // dot4x clocks per phi half-period
  localparam int SETUP_TICKS = 2;
  localparam int TIMEOUT_PHI = 16;

  logic       clk_dot4x = 1'b0;
  logic       rst_n     = 1'b0;
  logic       clk_phi   = 1'b0;
  logic       aec       = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [5:0] cmd_addr  = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       ce, rw, ad_oe, db_oe;
  logic [5:0] ad_o;
  logic [7:0] db_o;
  logic [7:0] db_i = 8'h00;

  vic_reg_bus_initiator dut (
    .clk_dot4x (clk_dot4x),
    .rst_n     (rst_n),
    .clk_phi   (clk_phi),
    .aec       (aec),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .ce        (ce),
    .rw        (rw),
    .ad_o      (ad_o),
    .ad_oe     (ad_oe),
    .db_o      (db_o),
    .db_oe     (db_oe),
    .db_i      (db_i)
  );

  always #5 clk_dot4x = ~clk_dot4x;

  // phi toggles on the falling dot clock edge, well away from the sampling posedge
  initial begin
    forever begin
      repeat (PHI_HALF) @(negedge clk_dot4x);
      clk_phi = ~clk_phi;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       wr;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic       aec;
    logic [7:0] bus;
    int         phase_wait;  // >0: issue that many clocks into a phi-high phase
    int         stall;       // clocks with rsp_ready low while rsp_valid is up
    logic       aec_drop;    // drop aec once ce is low
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  vec_t vecs[6];

  int   n_checks = 0;
  int   n_fail   = 0;
  logic phi_prev = 1'b0;
  logic phi_now  = 1'b0;
  logic rise_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance one dot clock and sample 1 time unit after the edge
  task automatic tick();
    @(posedge clk_dot4x);
    #1;
    phi_prev  = phi_now;
    phi_now   = clk_phi;
    rise_seen = phi_now & ~phi_prev;
  endtask

  task automatic run_cmd(input vec_t v);
    int rise_idx, ce_first, ce_len, rises, cnt;
    logic bus_ok;
    aec       = v.aec;
    db_i      = v.bus;
    rsp_ready = 1'b0;
    tick();
    cnt = 0;
    while (!cmd_ready && cnt < 50) begin
      tick();
      cnt++;
    end
    check("cmd_ready_before_issue", 32'(cmd_ready), 32'd1);
    if (v.phase_wait > 0) begin
      cnt = 0;
      while (!rise_seen && cnt < 4 * PHI_HALF) begin
        tick();
        cnt++;
      end
      repeat (v.phase_wait) tick();
    end
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    tick();
    cmd_valid = 1'b0;
    check("cmd_ready_after_accept", 32'(cmd_ready), 32'd0);

    rise_idx = -1;
    ce_first = -1;
    ce_len   = 0;
    rises    = 0;
    bus_ok   = 1'b1;
    for (int n = 0; n < 1200 && !rsp_valid; n++) begin
      tick();
      if (rise_seen) begin
        rises++;
        if (rise_idx < 0) rise_idx = n;
      end
      if (ad_oe !== ~ce) bus_ok = 1'b0;
      if (ce === 1'b0) begin
        if (ce_first < 0) ce_first = n;
        ce_len++;
        if (ad_o !== v.addr || rw !== ~v.wr || db_oe !== v.wr) bus_ok = 1'b0;
        if (v.wr && db_o !== v.wdata) bus_ok = 1'b0;
        if (v.aec_drop) aec = 1'b0;
      end else if (db_oe !== 1'b0) begin
        bus_ok = 1'b0;
      end
    end
    check("rsp_valid_arrives", 32'(rsp_valid), 32'd1);
    check("bus_drive", 32'(bus_ok), 32'd1);
    if (v.aec) begin
      check("ce_start_after_rise", 32'(ce_first - rise_idx), 32'(SETUP_TICKS));
      check("ce_low_length", 32'(ce_len), 32'(PHI_HALF - SETUP_TICKS));
    end else begin
      check("ce_never_low", 32'(ce_len), 32'd0);
      check("timeout_rises", 32'(rises), 32'(TIMEOUT_PHI));
    end
    check("rsp_rdata", 32'(rsp_rdata), 32'(v.exp_rdata));
    check("rsp_err", 32'(rsp_err), 32'(v.exp_err));
    check("cmd_ready_in_resp", 32'(cmd_ready), 32'd0);
    repeat (v.stall) begin
      tick();
      check("stall_hold", {22'd0, rsp_valid, cmd_ready, rsp_err, rsp_rdata},
            {22'd0, 1'b1, 1'b0, v.exp_err, v.exp_rdata});
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_valid_after_handshake", 32'(rsp_valid), 32'd0);
    check("cmd_ready_after_handshake", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int cnt;
    //          wr    addr   wdata  aec   bus    pw st drop  rdata  err
    vecs[0] = '{1'b1, 6'h20, 8'h06, 1'b1, 8'hEE, 0, 0, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 6'h12, 8'h00, 1'b1, 8'h37, 0, 0, 1'b0, 8'h37, 1'b0};
    vecs[2] = '{1'b0, 6'h05, 8'h00, 1'b0, 8'h11, 0, 0, 1'b0, 8'hFF, 1'b1};
    vecs[3] = '{1'b1, 6'h3F, 8'hFF, 1'b1, 8'h00, 5, 5, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{1'b0, 6'h00, 8'h00, 1'b1, 8'hA5, 8, 5, 1'b1, 8'hA5, 1'b0};
    vecs[5] = '{1'b1, 6'h15, 8'h5A, 1'b1, 8'h00, 0, 0, 1'b0, 8'h00, 1'b0};

    // Reset values while held in reset
    #12;
    check("reset_outputs",
          {5'd0, ce, rw, ad_oe, db_oe, ad_o, db_o, cmd_ready, rsp_valid, rsp_err, rsp_rdata},
          {5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00});
    @(negedge clk_dot4x);
    rst_n = 1'b1;
    #1;
    check("cmd_ready_at_release", 32'(cmd_ready), 32'd0);
    tick();
    check("cmd_ready_first_clock", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 5; i++) run_cmd(vecs[i]);

    // Asynchronous reset in the middle of an access
    aec       = 1'b1;
    db_i      = 8'h44;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 6'h2A;
    cmd_wdata = 8'h99;
    tick();
    cmd_valid = 1'b0;
    cnt = 0;
    while (ce !== 1'b0 && cnt < 200) begin
      tick();
      cnt++;
    end
    check("ce_low_before_reset", 32'(ce), 32'd0);
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {26'd0, ce, rw, ad_oe, db_oe, rsp_valid, cmd_ready},
          {26'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clk_dot4x);
    rst_n = 1'b1;
    tick();
    check("cmd_ready_after_rereset", 32'(cmd_ready), 32'd1);

    run_cmd(vecs[5]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
